imm_decode_queue: RTL and testbench

- Decode-side stage directly upstream of the immediate sign-extension stage.
- Accepts packed beats of DEPTH instruction words from fetch over a valid/ready handshake and extracts each lane's IMM_WIDTH-bit immediate field.
- Per lane, computes the signed/zero-extend decision from the opcode.
- Buffers decoded beats in a FIFO_DEPTH-entry queue; the head entry drives the extension stage's dataIn and per-lane sign control.

---
 rtl/imm_decode_queue.sv | 95 +++++++++
 tb/tb_imm_decode_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_queue.sv
// Decodes per-lane immediates and sign-extend controls from fetched instruction
// beats and queues them for the immediate sign-extension stage.
module imm_decode_queue #(
    parameter int INSTR_WIDTH = 32,
    parameter int IMM_WIDTH   = 16,
    parameter int DEPTH       = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [INSTR_WIDTH*DEPTH-1:0]         instrIn,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [IMM_WIDTH*DEPTH-1:0]           immOut,
    output logic [DEPTH-1:0]                     isSignedOut,
    output logic [$clog2(FIFO_DEPTH):0]          level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Logical immediates (ANDI/ORI/XORI) zero-extend; everything else sign-extends.
    function automatic logic is_signed_op(input logic [5:0] opcode);
        return !(opcode inside {6'h0C, 6'h0D, 6'h0E});
    endfunction

    logic [IMM_WIDTH*DEPTH-1:0] imm_p0;
    logic [DEPTH-1:0]           sgn_p0;

    logic [IMM_WIDTH*DEPTH-1:0] imm_mem [FIFO_DEPTH];
    logic [DEPTH-1:0]           sgn_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       push;
    logic                       pop;
    logic                       unused_instr_bits;

    always_comb begin
        imm_p0 = '0;
        sgn_p0 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            imm_p0[i*IMM_WIDTH +: IMM_WIDTH] = instrIn[i*INSTR_WIDTH +: IMM_WIDTH];
            sgn_p0[i] = is_signed_op(instrIn[i*INSTR_WIDTH + INSTR_WIDTH - 6 +: 6]);
        end
    end

    assign unused_instr_bits = ^instrIn;

    assign in_ready  = !rst && !en_n && (count != CNT_W'(FIFO_DEPTH));
    assign out_valid = !en_n && (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // ---- decode -> queue storage boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                imm_mem[i] <= '0;
                sgn_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                imm_mem[wr_ptr] <= imm_p0;
                sgn_mem[wr_ptr] <= sgn_p0;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // ---- queue head -> extension stage ----
    assign immOut      = imm_mem[rd_ptr];
    assign isSignedOut = sgn_mem[rd_ptr];
    assign level       = count;

endmodule

// File: tb/tb_imm_decode_queue.sv
// Directed bench for imm_decode_queue: reset, decode, fill/backpressure with wrap,
// concurrent push/pop, stall, flush and reset-over-flush.
module tb_imm_decode_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] instrIn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] immOut;
    logic [1:0]  isSignedOut;
    logic [2:0]  level;

    int n_cmp = 0;
    int n_err = 0;

    imm_decode_queue #(
        .INSTR_WIDTH(32),
        .IMM_WIDTH  (16),
        .DEPTH      (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_n       (en_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instrIn    (instrIn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .immOut     (immOut),
        .isSignedOut(isSignedOut),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Lane0 alternates XORI (0x0E, zero-ext) and LUI (0x0F, sign-ext); lane1 is LW (0x23).
    function automatic logic [63:0] beat(input int k);
        logic [31:0] l0;
        logic [31:0] l1;
        l0 = ((k % 2) != 0 ? 32'h3C00_0000 : 32'h3800_0000) | (32'h1100 + 32'(k));
        l1 = 32'h8C00_0000 | (32'h2200 + 32'(k));
        return {l1, l0};
    endfunction

    function automatic logic [31:0] exp_imm(input int k);
        return {16'h2200 + 16'(k), 16'h1100 + 16'(k)};
    endfunction

    function automatic logic [1:0] exp_sgn(input int k);
        return ((k % 2) != 0) ? 2'b11 : 2'b10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_head(input string tag, input int k);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_imm"}, immOut, exp_imm(k));
        chk({tag, "_sgn"}, 32'(isSignedOut), 32'(exp_sgn(k)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int k);
        instrIn  = beat(k);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_cmp++;
            assert (level <= 3'd4) else begin
                n_err++;
                $error("FAIL level_bound: observed %0d expected <= 4", level);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        en_n      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instrIn   = '0;

        // Reset and idle
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_imm", immOut, 32'h0);
        chk("idle_sgn", 32'(isSignedOut), 32'd0);

        // Decode: ADDI lane0, ORI lane1
        instrIn  = {32'h3409_ABCD, 32'h2008_FFFC};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("dec_vld", 32'(out_valid), 32'd1);
        chk("dec_imm", immOut, 32'hABCD_FFFC);
        chk("dec_sgn", 32'(isSignedOut), 32'd1);
        chk("dec_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("dec_pop_level", 32'(level), 32'd0);
        chk("dec_pop_vld", 32'(out_valid), 32'd0);

        // Fill with backpressure
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instrIn = beat(k);
            chk("fill_ready", 32'(in_ready), 32'd1);
            tick();
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        instrIn = beat(4);
        tick();
        chk("full_hold_level", 32'(level), 32'd4);
        chk_head("full_head", 0);
        // Pop at full: beat 4 must not pass through
        out_ready = 1'b1;
        chk("full_pop_ready", 32'(in_ready), 32'd0);
        tick();
        chk("after_full_pop_level", 32'(level), 32'd3);
        chk_head("drain1", 1);
        chk("free_slot_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("push_pop_level", 32'(level), 32'd3);
        chk_head("drain2", 2);
        tick();
        chk_head("drain3", 3);
        tick();
        chk_head("drain4_wrap", 4);
        tick();
        out_ready = 1'b0;
        chk("drained_level", 32'(level), 32'd0);
        chk("drained_vld", 32'(out_valid), 32'd0);

        // Concurrent push and pop at level 2
        push_beat(5);
        push_beat(6);
        chk("conc_level0", 32'(level), 32'd2);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            instrIn = beat(7 + i);
            chk_head("conc_head", 5 + i);
            tick();
            chk("conc_level", 32'(level), 32'd2);
        end
        in_valid = 1'b0;
        chk_head("conc_tail0", 11);
        tick();
        chk_head("conc_tail1", 12);
        tick();
        out_ready = 1'b0;
        chk("conc_done_level", 32'(level), 32'd0);

        // Stall at level 3
        push_beat(13);
        push_beat(14);
        push_beat(15);
        en_n      = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instrIn   = beat(16);
        #1;
        chk("stall_ready", 32'(in_ready), 32'd0);
        chk("stall_vld", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_level", 32'(level), 32'd3);
            chk("stall_imm", immOut, exp_imm(13));
            chk("stall_vld_hold", 32'(out_valid), 32'd0);
        end
        en_n     = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_head("resume0", 13);
        tick();
        chk_head("resume1", 14);
        tick();
        chk_head("resume2", 15);
        tick();
        out_ready = 1'b0;
        chk("resume_level", 32'(level), 32'd0);

        // Flush with push and pop requested
        push_beat(17);
        push_beat(18);
        push_beat(19);
        chk("pre_flush_level", 32'(level), 32'd3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instrIn   = beat(20);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_vld", 32'(out_valid), 32'd0);
        push_beat(21);
        chk_head("post_flush_head", 21);
        chk("post_flush_level", 32'(level), 32'd1);

        // Flush during stall
        push_beat(22);
        push_beat(23);
        chk("pre_flush2_level", 32'(level), 32'd3);
        flush    = 1'b1;
        en_n     = 1'b1;
        in_valid = 1'b1;
        instrIn  = beat(25);
        tick();
        flush    = 1'b0;
        en_n     = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush2_level", 32'(level), 32'd0);
        chk("flush2_vld", 32'(out_valid), 32'd0);
        push_beat(24);
        chk_head("post_flush2_head", 24);

        // Reset overrides flush and stall and clears storage
        rst   = 1'b1;
        flush = 1'b1;
        en_n  = 1'b1;
        tick();
        chk("rst2_ready", 32'(in_ready), 32'd0);
        rst   = 1'b0;
        flush = 1'b0;
        en_n  = 1'b0;
        #1;
        chk("rst2_level", 32'(level), 32'd0);
        chk("rst2_vld", 32'(out_valid), 32'd0);
        chk("rst2_imm", immOut, 32'h0);
        chk("rst2_sgn", 32'(isSignedOut), 32'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
